// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   NOP_INSTR        : instruction word emitted as a bubble
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_entry_t    : one prefetch queue entry {pc, instr}
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction memory req/ack bus.
//   IMem_Addr : fetch address, stable while IMem_Req is high
//   IMem_Req  : fetch request
//   IMem_Ack  : request accepted, IMem_Data valid in the same cycle
//   IMem_Data : returned instruction word
// master = fetch stage, slave = instruction memory.
interface fetch_if;

  logic [31:0] IMem_Addr;
  logic        IMem_Req;
  logic        IMem_Ack;
  logic [31:0] IMem_Data;

  modport master (output IMem_Addr, IMem_Req, input  IMem_Ack, IMem_Data);
  modport slave  (input  IMem_Addr, IMem_Req, output IMem_Ack, IMem_Data);

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch_entry_t used as the prefetch queue.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/push_data : write an entry (ignored when full)
//   pop        : advance the head (ignored when empty)
//   flush      : empty the queue; wins over push and pop in the same cycle
//   head       : current head entry (valid when !empty)
//   full/empty/count : occupancy status
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   mem_d [DEPTH];
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign head  = mem_q[rd_q];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + 1'b1;   // DEPTH is a power of 2: pointers wrap naturally
      end
      if (do_pop) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Issues sequential word fetches over a
// single-outstanding req/ack bus, buffers words with their PCs in a
// prefetch queue and hands one instruction (or a NOP bubble) per cycle
// to decode. Handles decode redirects and freeze requests.
//   CLK, RESET         : clock, asynchronous active-low reset
//   Alt_PC             : redirect target (low two bits ignored)
//   Request_Alt_PC     : redirect strobe
//   WANT_FREEZE        : hold the decode-facing outputs
//   imem               : instruction memory bus (master side)
//   Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT : instruction to decode
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Alt_PC,
  input  logic        Request_Alt_PC,
  input  logic        WANT_FREEZE,
  fetch_if.master     imem,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4_OUT
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;
  logic         discard_q, discard_d;
  logic         pending_q, pending_d;
  logic [31:0]  pending_pc_q, pending_pc_d;
  logic [31:0]  instr_q, instr_d, pc_q, pc_d, pc4_q, pc4_d;

  logic         ack, hold_req, redirect_now;
  logic [31:0]  alt_aligned, target;
  logic         q_push, q_pop, q_flush, q_full, q_empty;
  logic [CW-1:0] q_count, count_after;
  fetch_entry_t q_in, q_head;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk      (CLK),
    .rst_n    (RESET),
    .push     (q_push),
    .push_data(q_in),
    .pop      (q_pop),
    .flush    (q_flush),
    .head     (q_head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  assign imem.IMem_Req    = req_q;
  assign imem.IMem_Addr   = addr_q;
  assign Instr1_OUT         = instr_q;
  assign Instr_PC_OUT       = pc_q;
  assign Instr_PC_Plus4_OUT = pc4_q;

  always_comb begin
    ack          = req_q && imem.IMem_Ack;
    hold_req     = req_q && !imem.IMem_Ack;
    alt_aligned  = Alt_PC & 32'hFFFF_FFFC;
    // A redirect captured during freeze is applied at the first unfrozen edge;
    // a fresh strobe on that edge supersedes the captured target.
    redirect_now = !WANT_FREEZE && (Request_Alt_PC || pending_q);
    target       = Request_Alt_PC ? alt_aligned : pending_pc_q;

    q_flush    = Request_Alt_PC || redirect_now;
    q_push     = ack && !discard_q && !q_full;
    q_pop      = !WANT_FREEZE && !redirect_now && !q_empty;
    q_in.pc    = fetch_pc_q;
    q_in.instr = imem.IMem_Data;

    fetch_pc_d   = fetch_pc_q;
    discard_d    = discard_q;
    pending_d    = pending_q;
    pending_pc_d = pending_pc_q;

    if (q_push) fetch_pc_d = fetch_pc_q + 32'd4;
    if (ack && discard_q) discard_d = 1'b0;

    if (redirect_now) begin
      fetch_pc_d = target;
      discard_d  = hold_req;   // the in-flight word belongs to the old path
      pending_d  = 1'b0;
    end else if (WANT_FREEZE && Request_Alt_PC) begin
      pending_d    = 1'b1;
      pending_pc_d = alt_aligned;
    end

    count_after = q_flush ? '0 : (q_count + CW'(q_push) - CW'(q_pop));

    // Req/Addr stay put until acked; afterwards a new request goes out only
    // if the word can still be stored.
    if (hold_req) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else begin
      req_d  = (count_after < CW'(QUEUE_DEPTH));
      addr_d = fetch_pc_d;
    end
  end

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    if (!WANT_FREEZE) begin
      if (q_pop) begin
        instr_d = q_head.instr;
        pc_d    = q_head.pc;
        pc4_d   = q_head.pc + 32'd4;
      end else begin
        instr_d = NOP_INSTR;
        pc_d    = '0;
        pc4_d   = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fetch_pc_q   <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      discard_q    <= 1'b0;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
      instr_q      <= '0;
      pc_q         <= '0;
      pc4_q        <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      discard_q    <= discard_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      pc4_q        <= pc4_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// ack/freeze/redirect traffic, compared every cycle against a queue-level model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int          NCYC   = 2080;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] Alt_PC;
  logic        Request_Alt_PC;
  logic        WANT_FREEZE;
  logic [31:0] Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT;

  fetch_if imem();

  fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(DEPTH)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .Alt_PC            (Alt_PC),
    .Request_Alt_PC    (Request_Alt_PC),
    .WANT_FREEZE       (WANT_FREEZE),
    .imem              (imem),
    .Instr1_OUT        (Instr1_OUT),
    .Instr_PC_OUT      (Instr_PC_OUT),
    .Instr_PC_Plus4_OUT(Instr_PC_Plus4_OUT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: what the outputs and the bus must look like after each edge.
  fetch_entry_t mq[$];
  logic [31:0]  m_fpc, m_addr, m_ppc, m_i, m_pc, m_pc4;
  bit           m_req, m_disc, m_pend;
  bit           a_drv;

  // Redirect watches: from a given cycle the outputs show a bubble, and the
  // first valid instruction afterwards must come from the target.
  int          wfrom [3] = '{13, 21, 45};
  logic [31:0] wpc   [3] = '{32'h400, 32'h200, 32'h800};
  int          widx = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;   // never zero for aligned a
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    bit           ack, rnow;
    logic [31:0]  tgt;
    fetch_entry_t e;
    ack  = m_req && a_drv;
    rnow = !WANT_FREEZE && (Request_Alt_PC || m_pend);
    tgt  = Request_Alt_PC ? {Alt_PC[31:2], 2'b00} : m_ppc;
    if (!WANT_FREEZE) begin
      if (rnow || mq.size() == 0) begin
        m_i = '0; m_pc = '0; m_pc4 = '0;
      end else begin
        e = mq.pop_front();
        m_i = e.instr; m_pc = e.pc; m_pc4 = e.pc + 32'd4;
      end
    end
    if (ack) begin
      if (m_disc) m_disc = 0;
      else begin
        e.pc = m_fpc; e.instr = mem_word(m_fpc);
        mq.push_back(e);
        m_fpc = m_fpc + 32'd4;
      end
    end
    if (Request_Alt_PC || rnow) mq.delete();
    if (rnow) begin
      m_disc = m_req && !ack;
      m_fpc  = tgt;
      m_pend = 0;
    end else if (WANT_FREEZE && Request_Alt_PC) begin
      m_pend = 1;
      m_ppc  = tgt;
    end
    if (!(m_req && !ack)) begin
      m_req  = (mq.size() < int'(DEPTH));
      m_addr = m_fpc;
    end
  endtask

  task automatic compare();
    chk("IMem_Req",  {31'b0, imem.IMem_Req}, {31'b0, m_req});
    chk("IMem_Addr", imem.IMem_Addr, m_addr);
    chk("Instr1",    Instr1_OUT, m_i);
    chk("InstrPC",   Instr_PC_OUT, m_pc);
    chk("InstrPC4",  Instr_PC_Plus4_OUT, m_pc4);
    if (Instr1_OUT != 32'h0) begin
      chk("word_matches_pc", Instr1_OUT, mem_word(Instr_PC_OUT));
      chk("pc4_is_pc_plus4", Instr_PC_Plus4_OUT, Instr_PC_OUT + 32'd4);
    end
    case (cyc)
      1: begin
        chk("first_req",  {31'b0, imem.IMem_Req}, 32'd1);
        chk("first_addr", imem.IMem_Addr, 32'h0);
      end
      2: chk("second_addr", imem.IMem_Addr, 32'h4);
      3: begin
        chk("first_instr", Instr1_OUT, mem_word(32'h0));
        chk("first_pc",    Instr_PC_OUT, 32'h0);
        chk("first_pc4",   Instr_PC_Plus4_OUT, 32'h4);
      end
      4: chk("second_pc", Instr_PC_OUT, 32'h4);
      24: begin
        chk("reissue_req",  {31'b0, imem.IMem_Req}, 32'd1);
        chk("reissue_addr", imem.IMem_Addr, 32'h200);
      end
      35: chk("full_no_req", {31'b0, imem.IMem_Req}, 32'd0);
      default: ;
    endcase
    if (widx < 3) begin
      if (cyc == wfrom[widx]) begin
        chk("redir_bubble_instr", Instr1_OUT, 32'h0);
        chk("redir_bubble_pc",    Instr_PC_OUT, 32'h0);
        chk("redir_bubble_pc4",   Instr_PC_Plus4_OUT, 32'h0);
      end else if (cyc > wfrom[widx] && Instr1_OUT != 32'h0) begin
        chk("redir_target_pc", Instr_PC_OUT, wpc[widx]);
        widx++;
      end
    end
  endtask

  task automatic drive(input int c);
    bit          ack_in, fr, rd;
    logic [31:0] alt;
    ack_in = 1; fr = 0; rd = 0; alt = '0;
    if (c == 12) begin
      rd = 1; alt = 32'h400;
    end else if (c >= 20 && c <= 22) begin
      ack_in = 0;
      if (c == 20) begin rd = 1; alt = 32'h200; end
    end else if (c >= 30 && c <= 34) begin
      fr = 1;
    end else if (c >= 40 && c <= 43) begin
      fr = 1;
      if (c == 41) begin rd = 1; alt = 32'h803; end
    end else if (c >= 50 && c < 80) begin
      ack_in = (c % 3 == 0);
    end else if (c >= 80) begin
      ack_in = ($urandom_range(0, 99) < 60);
      fr     = ($urandom_range(0, 99) < 15);
      rd     = ($urandom_range(0, 99) < 6);
      alt    = $urandom;
    end
    WANT_FREEZE    = fr;
    Request_Alt_PC = rd;
    Alt_PC         = alt;
    a_drv          = ack_in && m_req;
    imem.IMem_Ack  = a_drv;
    imem.IMem_Data = a_drv ? mem_word(m_addr) : 32'hDEAD_BEEF;
  endtask

  initial begin
    Alt_PC = '0; Request_Alt_PC = 0; WANT_FREEZE = 0; a_drv = 0;
    imem.IMem_Ack = 0; imem.IMem_Data = '0;
    m_fpc = '0; m_addr = '0; m_ppc = '0; m_i = '0; m_pc = '0; m_pc4 = '0;
    m_req = 0; m_disc = 0; m_pend = 0;

    repeat (2) @(negedge CLK);
    chk("reset_req",   {31'b0, imem.IMem_Req}, 32'd0);
    chk("reset_addr",  imem.IMem_Addr, 32'h0);
    chk("reset_instr", Instr1_OUT, 32'h0);
    chk("reset_pc",    Instr_PC_OUT, 32'h0);
    chk("reset_pc4",   Instr_PC_Plus4_OUT, 32'h0);

    RESET = 1'b1;
    cyc = 0;
    drive(0);
    for (int c = 1; c <= NCYC; c++) begin
      @(negedge CLK);
      cyc = c;
      step();
      compare();
      drive(c);
    end

    checks++;
    if (widx != 3) begin
      errors++;
      $display("FAIL redirect_watches: resolved %0d expected 3", widx);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the decode stage. Issues sequential word fetches to instruction memory over a single-outstanding req/ack handshake, buffers returned words with their PCs in a small prefetch queue, and presents one instruction per cycle (or a NOP bubble) to decode. Honours decode's branch/jump redirect (flush plus discard of the in-flight response) and decode's freeze request.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- QUEUE_DEPTH, 4, prefetch queue entries; power of 2, minimum 2

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- Alt_PC  in  32  redirect target from decode
- Request_Alt_PC  in  1  redirect strobe from decode
- WANT_FREEZE  in  1  decode asks fetch to hold its outputs
- IMem_Addr  out  32  fetch address; stable while IMem_Req is high
- IMem_Req  out  1  fetch request
- IMem_Ack  in  1  request accepted; IMem_Data valid in the same cycle
- IMem_Data  in  32  returned instruction word
- Instr1_OUT  out  32  instruction to decode (Instr1_IN)
- Instr_PC_OUT  out  32  its PC (Instr_PC_IN)
- Instr_PC_Plus4_OUT  out  32  its PC+4 (Instr_PC_Plus4_IN)

## Operation
- Reset values (asynchronous): Instr1_OUT=0, Instr_PC_OUT=0, Instr_PC_Plus4_OUT=0, IMem_Req=0, IMem_Addr=RESET_PC, fetch_pc=RESET_PC, queue empty, discard=0, pending=0.
- Issue: IMem_Req=1 whenever occupancy + outstanding < QUEUE_DEPTH. IMem_Addr=fetch_pc. Addr and Req hold until the ack cycle. At most one request outstanding.
- Ack edge: if discard=0, push {fetch_pc, IMem_Data}; fetch_pc += 4 (mod 2^32 wrap). If discard=1, drop the word and clear discard.
- Output edge when not frozen: if queue non-empty, pop the head to Instr1_OUT / Instr_PC_OUT / Instr_PC_Plus4_OUT (PC+4, wrap). If empty, emit a bubble: all three outputs 0.
- Freeze (WANT_FREEZE=1): all three outputs hold. Queue and issue continue up to full.
- Redirect (Request_Alt_PC=1, not frozen) at edge: flush queue; outputs take a bubble; fetch_pc <= {Alt_PC[31:2],2'b00}. If a request is outstanding and not acked this edge, set discard=1 and keep Req/Addr until ack, then reissue from the new PC. An ack on the same edge is dropped.
- Redirect while frozen: flush queue, capture target in pending_pc, set pending=1, keep outputs held. At the first unfrozen edge apply as a redirect (bubble out). A newer Request_Alt_PC overrides pending_pc.
- The delay slot is preserved: it is already in decode when Request_Alt_PC arrives. Only younger words are squashed.

## Timing
- Ack at edge t -> word visible on Instr1_OUT after edge t+1 at the earliest. No same-cycle bypass.
- Redirect at edge t -> first request to target at cycle t (or the cycle after the discarded ack). Target on outputs no earlier than edge t+2 after its ack.
- Steady state with IMem_Ack tied high: one instruction per cycle.
- Full: no new request. Push and pop on the same edge keep occupancy constant. Pop on empty emits a bubble and does not underflow.
- Priority: reset > freeze-hold of outputs > redirect > pop.

## Structure
- Package fetch_pkg holds: NOP_INSTR (32'h0), the fetch_entry_t typedef {pc[31:0], instr[31:0]}, and the RESET_PC default.
- One sub-module, fetch_queue: sync FIFO of fetch_entry_t with push, pop, flush, full, empty and count outputs. Flush has priority over push in the same cycle.
- The top level holds fetch_pc, the discard/pending flags, and the output registers.

## Test plan
- Reset release, ack tied high -> IMem_Addr 0x0,0x4,0x8…; Instr1_OUT shows mem[0] with PC 0 and PC+4 4, then one instruction per cycle.
- Redirect to 0x400 while 3 words are queued -> one bubble, no word from 0x10-0x1C appears, next valid Instr_PC_OUT=0x400.
- Redirect while a request to 0x20 is outstanding and acked 3 cycles later -> 0x20 word dropped, next IMem_Addr=0x400.
- WANT_FREEZE high for 5 cycles -> outputs constant, queue fills to 4, IMem_Req drops; after release the next 4 PCs appear in consecutive cycles.
- Freeze with Request_Alt_PC (Alt_PC=0x803) -> outputs held; after unfreeze, a bubble, then PC 0x800.
- Ack every 3rd cycle -> bubbles (all outputs 0) between valid words, no duplicates, PCs strictly +4.
